tpu_skew_feeder: RTL and testbench

- Operand feeder for the systolic MAC array's A (row) inputs.
- Buffers a DIM x DIM signed A matrix written one row per cycle.
- On start, drives one lane per array row, with lane i delayed i cycles (diagonal skew), so the row of MAC cells receives A in wavefront order.
- Also generates the array's `en` strobe (`en_out`) and a completion pulse for the controlling sequencer.

---
 rtl/tpu_skew_feeder.sv | 142 ++++++++++++++
 tb/tb_tpu_skew_feeder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tpu_skew_feeder.sv
// tpu_skew_feeder
//   Operand feeder for the A (row) inputs of a DIM x DIM systolic MAC array.
//   A signed DIM x DIM matrix is loaded one row per cycle into an internal
//   buffer. A start pulse then replays the matrix as 2*DIM-1 diagonal
//   wavefronts, lane i lagging lane 0 by i cycles, so each row of MAC cells
//   sees its operands in wavefront order. The enable strobe for the array
//   and a one-cycle completion pulse are produced alongside.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   wr_en    in   write one buffer row this cycle (IDLE only)
//   wr_row   in   buffer row index to write
//   wr_data  in   row data, column j at [j*BITS_AB +: BITS_AB]
//   start    in   begin a feed sequence (IDLE only, wins over wr_en)
//   busy     out  high while feeding
//   en_out   out  MAC array enable, high on every valid wavefront
//   done     out  one-cycle pulse after the last wavefront
//   Aout     out  skewed lanes, lane i at [i*BITS_AB +: BITS_AB]
module tpu_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWW    = $clog2(DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ROWW-1:0]        wr_row,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   en_out,
  output logic                   done,
  output logic [DIM*BITS_AB-1:0] Aout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FEED = 1'b1;

  // Counter must hold the last wavefront index 2*DIM-2.
  localparam int CNTW = $clog2(2*DIM - 1);
  localparam logic [CNTW-1:0] LAST_T = CNTW'(2*DIM - 2);

  logic [0:0]             state_q, state_d;
  logic [CNTW-1:0]        t_q, t_d;
  logic                   en_q, en_d;
  logic                   done_q, done_d;
  logic [DIM*BITS_AB-1:0] aout_q, aout_d;
  logic [BITS_AB-1:0]     matBuf_q [DIM][DIM];

  logic [DIM*BITS_AB-1:0] waveNext;
  int                     waveIdx;
  logic                   rowWrite;

  // Wavefront for the next cycle: index 0 when launching from IDLE,
  // t+1 while feeding. Lane i carries column (waveIdx - i) of row i,
  // i.e. the element whose row+column equals the wavefront index.
  always_comb begin
    waveNext = '0;
    waveIdx  = (state_q == FEED) ? int'(t_q) + 1 : 0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (i + j == waveIdx) begin
          waveNext[i*BITS_AB +: BITS_AB] = matBuf_q[i][j];
        end
      end
    end
  end

  // Buffer writes only land in IDLE, without a coincident start, and only
  // for rows that exist (no wrap for non-power-of-two DIM).
  assign rowWrite = (state_q == IDLE) && !start && wr_en && (int'(wr_row) < DIM);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    aout_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          t_d     = '0;
          en_d    = 1'b1;
          aout_d  = waveNext;
        end
      end
      FEED: begin
        if (t_q == LAST_T) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d    = t_q + CNTW'(1);
          en_d   = 1'b1;
          aout_d = waveNext;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      aout_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      en_q    <= en_d;
      done_q  <= done_d;
      aout_q  <= aout_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          matBuf_q[i][j] <= '0;
        end
      end
    end else if (rowWrite) begin
      for (int j = 0; j < DIM; j++) begin
        matBuf_q[wr_row][j] <= wr_data[j*BITS_AB +: BITS_AB];
      end
    end
  end

  assign busy   = (state_q == FEED);
  assign en_out = en_q;
  assign done   = done_q;
  assign Aout   = aout_q;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// tb_tpu_skew_feeder
//   Self-checking bench for tpu_skew_feeder at DIM=4, BITS_AB=8. A matrix
//   model held in the bench supplies every expected wavefront from the
//   diagonal rule lane i = A[i][k-i].
module tb_tpu_skew_feeder;

  localparam int BITS = 8;
  localparam int DIM  = 4;
  localparam int ROWW = $clog2(DIM);
  localparam int W    = DIM*BITS;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [ROWW-1:0] wr_row = '0;
  logic [W-1:0]    wr_data = '0;
  logic            start = 1'b0;
  logic            busy;
  logic            en_out;
  logic            done;
  logic [W-1:0]    Aout;

  logic [BITS-1:0] mdl [DIM][DIM];
  int              checkCount = 0;
  int              passCount  = 0;

  tpu_skew_feeder #(.BITS_AB(BITS), .DIM(DIM), .ROWW(ROWW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .start(start), .busy(busy), .en_out(en_out), .done(done), .Aout(Aout)
  );

  always #5 clk = ~clk;

  // Expected lanes for wavefront k from the matrix model.
  function automatic logic [W-1:0] expWave(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++) begin
      if (k - i >= 0 && k - i < DIM) r[i*BITS +: BITS] = mdl[i][k-i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input int row, input logic [W-1:0] data,
                               input logic st);
    wr_en   = we;
    wr_row  = ROWW'(row);
    wr_data = data;
    start   = st;
  endtask

  task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] expA, input logic expEn,
                             input logic expDone);
    checkValue({tag, ".Aout"}, Aout, expA);
    checkValue({tag, ".en_out"}, W'(en_out), W'(expEn));
    checkValue({tag, ".busy"}, W'(busy), W'(expEn));
    checkValue({tag, ".done"}, W'(done), W'(expDone));
  endtask

  // Load a row into DUT and model (one cycle).
  task automatic loadRow(input int row, input logic [W-1:0] data);
    applyStimulus(1'b1, row, data, 1'b0);
    tick();
    for (int j = 0; j < DIM; j++) mdl[row][j] = data[j*BITS +: BITS];
    applyStimulus(1'b0, 0, '0, 1'b0);
  endtask

  task automatic loadRandom();
    logic [W-1:0] d;
    for (int i = 0; i < DIM; i++) begin
      d = W'($urandom);
      loadRow(i, d);
    end
  endtask

  // Caller has already driven start for the coming edge. Runs a whole feed:
  // 2*DIM-1 wavefront cycles then the done cycle.
  task automatic runFeed(input string tag, input bit chainNext, input bit injectIgnored);
    for (int c = 1; c <= 2*DIM; c++) begin
      tick();
      if (c < 2*DIM) checkOutput($sformatf("%s.c%0d", tag, c), expWave(c-1), 1'b1, 1'b0);
      else           checkOutput($sformatf("%s.done", tag), '0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, '0, 1'b0);
      if (injectIgnored && c == 2) applyStimulus(1'b1, 0, {DIM{8'hAA}}, 1'b1);
      if (chainNext && c == 2*DIM) start = 1'b1;
    end
  endtask

  task automatic checkIdle(input string tag);
    tick();
    checkOutput(tag, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mdl[i][j] = '0;

    // Reset asserted between edges: outputs clear with no clock.
    #2 rst = 1'b1;
    #1 checkOutput("reset_async", '0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkIdle("after_reset");

    // Directed matrix A[i][j] = 16i+j+1 with spot checks of known lanes.
    for (int i = 0; i < DIM; i++) begin
      logic [W-1:0] d;
      for (int j = 0; j < DIM; j++) d[j*BITS +: BITS] = BITS'(16*i + j + 1);
      loadRow(i, d);
    end
    applyStimulus(1'b0, 0, '0, 1'b1);
    for (int c = 1; c <= 2*DIM; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) checkValue("dir.c1", Aout, 32'h00000001);
      if (c == 4) checkValue("dir.c4", Aout, 32'h31221304);
      if (c == 7) checkValue("dir.c7", Aout, 32'h34000000);
      if (c < 2*DIM) checkOutput($sformatf("dir.c%0d", c), expWave(c-1), 1'b1, 1'b0);
      else           checkOutput("dir.done", '0, 1'b0, 1'b1);
    end
    checkIdle("dir.idle");

    // Signed pass-through, two feeds back-to-back with start on done.
    loadRow(2, {8'h00, 8'hFF, 8'h7F, 8'h80});
    applyStimulus(1'b0, 0, '0, 1'b1);
    runFeed("signed1", 1'b1, 1'b0);
    runFeed("signed2", 1'b0, 1'b0);
    checkIdle("signed.idle");

    // Inputs during FEED are ignored; replay shows original row 0.
    applyStimulus(1'b0, 0, '0, 1'b1);
    runFeed("ignored", 1'b0, 1'b1);
    applyStimulus(1'b0, 0, '0, 1'b1);
    runFeed("ignored.replay", 1'b0, 1'b0);

    // start with wr_en: start wins, write is dropped.
    applyStimulus(1'b1, 1, {DIM{8'h55}}, 1'b1);
    runFeed("collide", 1'b0, 1'b0);
    applyStimulus(1'b0, 0, '0, 1'b1);
    runFeed("collide.replay", 1'b0, 1'b0);

    // Reset while feeding at t=3: immediate clear, no done, buffer cleared.
    applyStimulus(1'b0, 0, '0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      checkOutput($sformatf("abort.c%0d", c), expWave(c-1), 1'b1, 1'b0);
    end
    #2 rst = 1'b1;
    #1 checkOutput("abort.async", '0, 1'b0, 1'b0);
    for (int i = 0; i < DIM; i++) for (int j = 0; j < DIM; j++) mdl[i][j] = '0;
    tick();
    rst = 1'b0;
    checkIdle("abort.nodone");
    checkIdle("abort.nodone2");
    applyStimulus(1'b0, 0, '0, 1'b1);
    runFeed("abort.cleared", 1'b0, 1'b0);

    // Randomized matrices after the abort.
    for (int n = 0; n < 4; n++) begin
      loadRandom();
      applyStimulus(1'b0, 0, '0, 1'b1);
      runFeed($sformatf("rand%0d", n), (n == 2), 1'b0);
      if (n == 2) runFeed("rand2.chain", 1'b0, 1'b0);
      checkIdle($sformatf("rand%0d.idle", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
